id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register, directly downstream of the main opcode decoder.
- Captures decoder control bits plus ID-stage operands each cycle and presents them registered to the EX stage.
- Contains load-use hazard detection: raises a stall to PC/IF-ID and inserts a bubble (all control zero).
- Supports flush on taken branch/jump, whole-stage hold, and a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, width of register operands, sign-extended immediate and PC+4
- REG_AW, 5, register-file address width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  freeze all stage contents (downstream stall)
- flush  in  1  squash instruction entering this cycle (taken branch/jump)
- id_valid  in  1  ID holds a real instruction
- id_jump, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite, id_regdst  in  1 each  decoder control bits
- id_aluop  in  2  decoder ALU-op class
- id_uses_rt  in  1  instruction reads rt as a source (R-type, BEQ, SW)
- id_rs, id_rt, id_rd  in  REG_AW  register fields
- id_rs_data, id_rt_data, id_imm, id_pc4  in  DATA_W  operands
- ex_* (same set as id_* minus id_uses_rt, plus ex_valid)  out  same widths  registered copies
- stall  out  1  load-use hazard: PC and IF/ID must not update
- bubble_cnt  out  CNT_W  number of bubbles inserted since reset

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs = 0, ex_aluop = 2'b00, bubble_cnt = 0. stall is then 0, because ex_memread = 0.
- stall (combinational), high only when all of the following hold:
  - ex_valid & ex_memread
  - ex_rt != 0
  - (ex_rt == id_rs) or (id_uses_rt & ex_rt == id_rt)
  - id_valid
- Register update at posedge, priority highest first:
  - hold=1: all ex_* keep their values, including in the flush/stall cases; bubble_cnt is unchanged. stall is still computed from the held contents.
  - flush=1: ex_valid=0; all control bits and ex_aluop = 0. Data/address fields may load the ID values (don't-care). No count.
  - stall=1: insert a bubble. Same clearing as flush, and bubble_cnt increments.
  - Otherwise: every ex_* = id_*; ex_valid = id_valid.
- If id_valid=0 on a normal load, the control bits are forced to 0, so invalid slots never write.
- Latency: one cycle from id_* to ex_*.
- A bubble lasts exactly one cycle. The next cycle, ex_memread=0, so stall drops and the stalled instruction (held upstream) loads normally.
- bubble_cnt saturates at all-ones; it never wraps.
- flush and stall in the same cycle: flush wins, no count. stall is still driven high combinationally; upstream handles the flush priority.
- Register $0 never causes a hazard.
- Reset asserted mid-operation clears the stage immediately, independent of clk.

Test Plan:
1. Reset: assert rst_n=0 mid-stream with ex_regwrite=1 -> all ex_* drop to 0 before the next edge; stall=0; bubble_cnt=0.
2. Pass-through: R-type (regwrite=1, regdst=1, aluop=10, rs=3, rt=4, rd=5, rs_data=0x11) -> ex_* match one cycle later, ex_valid=1, stall=0.
3. Load-use: LW rt=8 followed by ADD rs=8 -> stall=1 for one cycle; next ex_* all control 0; bubble_cnt=1; following cycle ADD loads.
4. rt gating: LW rt=8 then ADDI rt=8 (id_uses_rt=0, rs=2) -> no stall. Same with SW (id_uses_rt=1) -> stall=1. LW rt=0 followed by a consumer of $0 -> no stall.
5. Flush/hold: flush with BEQ in ID -> ex_valid=0, ex_branch=0, no count. Hold=1 for 3 cycles while the ID inputs change -> ex_* unchanged.
6. Saturation: CNT_W=4, force 20 load-use pairs -> bubble_cnt stops at 15.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush, hold
// and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_jump,
  input  logic              id_branch,
  input  logic              id_memread,
  input  logic              id_memtoreg,
  input  logic              id_memwrite,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_regdst,
  input  logic [1:0]        id_aluop,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  output logic              ex_valid,
  output logic              ex_jump,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_alusrc,
  output logic              ex_regwrite,
  output logic              ex_regdst,
  output logic [1:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [9:0]        w_id_ctl;
  logic              w_rt_hit;
  logic              w_stall;
  logic              w_kill;
  logic              w_cnt_sat;

  logic              r_valid;
  logic [9:0]        r_ctl;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;
  logic [CNT_W-1:0]  r_cnt;

  assign w_id_ctl = {id_jump, id_branch, id_memread, id_memtoreg,
                     id_memwrite, id_alusrc, id_regwrite, id_regdst,
                     id_aluop};

  // r_ctl[7] is memread; a load into $0 never produces a value
  assign w_rt_hit  = (r_rt == id_rs) |
                     (id_uses_rt & (r_rt == id_rt));
  assign w_stall   = r_valid & r_ctl[7] & (r_rt != '0) &
                     w_rt_hit & id_valid;
  assign w_kill    = flush | w_stall;
  assign w_cnt_sat = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ctl     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_pc4     <= '0;
      r_cnt     <= '0;
    end else if (!hold) begin
      r_valid   <= id_valid & ~w_kill;
      r_ctl     <= (w_kill | ~id_valid) ? '0 : w_id_ctl;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_pc4     <= id_pc4;
      if (w_stall & ~flush & ~w_cnt_sat)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ex_valid    = r_valid;
  assign ex_jump     = r_ctl[9];
  assign ex_branch   = r_ctl[8];
  assign ex_memread  = r_ctl[7];
  assign ex_memtoreg = r_ctl[6];
  assign ex_memwrite = r_ctl[5];
  assign ex_alusrc   = r_ctl[4];
  assign ex_regwrite = r_ctl[3];
  assign ex_regdst   = r_ctl[2];
  assign ex_aluop    = r_ctl[1:0];
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_rd       = r_rd;
  assign ex_rs_data  = r_rs_data;
  assign ex_rt_data  = r_rt_data;
  assign ex_imm      = r_imm;
  assign ex_pc4      = r_pc4;
  assign stall       = w_stall;
  assign bubble_cnt  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed sequences, per-cycle model compare
// plus literal spot checks.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  // {jump,branch,memread,memtoreg,memwrite,alusrc,regwrite,regdst,aluop}
  localparam logic [9:0] C_NOP  = 10'b0000000000;
  localparam logic [9:0] C_RTYP = 10'b0000001110;
  localparam logic [9:0] C_LW   = 10'b0011011000;
  localparam logic [9:0] C_ADDI = 10'b0000011000;
  localparam logic [9:0] C_SW   = 10'b0000110000;
  localparam logic [9:0] C_BEQ  = 10'b0100000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic flush = 1'b0;
  logic id_valid = 1'b0;
  logic [9:0] id_ctl = '0;
  logic id_uses_rt = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [DW-1:0] id_rs_data = '0, id_rt_data = '0;
  logic [DW-1:0] id_imm = '0, id_pc4 = '0;

  logic ex_valid, ex_jump, ex_branch, ex_memread, ex_memtoreg;
  logic ex_memwrite, ex_alusrc, ex_regwrite, ex_regdst;
  logic [1:0] ex_aluop;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic stall;
  logic [CW-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid),
    .id_jump(id_ctl[9]), .id_branch(id_ctl[8]),
    .id_memread(id_ctl[7]), .id_memtoreg(id_ctl[6]),
    .id_memwrite(id_ctl[5]), .id_alusrc(id_ctl[4]),
    .id_regwrite(id_ctl[3]), .id_regdst(id_ctl[2]),
    .id_aluop(id_ctl[1:0]), .id_uses_rt(id_uses_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc4(id_pc4),
    .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_regdst(ex_regdst),
    .ex_aluop(ex_aluop), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the EX stage holds, kept as plain variables
  logic m_valid = 1'b0;
  logic [9:0] m_ctl = '0;
  logic [AW-1:0] m_rs = '0, m_rt = '0, m_rd = '0;
  logic [DW-1:0] m_rsd = '0, m_rtd = '0, m_imm = '0, m_pc4 = '0;
  int m_cnt = 0;

  function automatic logic m_stall();
    logic is_load;
    logic reads;
    is_load = m_valid && m_ctl == C_LW;
    reads = (id_rs == m_rt) || (id_uses_rt && id_rt == m_rt);
    return is_load && m_rt != 0 && id_valid && reads;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_ctl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      m_rsd = '0; m_rtd = '0; m_imm = '0; m_pc4 = '0; m_cnt = 0;
    end else if (!hold) begin
      if (flush) begin
        m_valid = 0;
        m_ctl = '0;
      end else if (m_stall()) begin
        m_valid = 0;
        m_ctl = '0;
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end else begin
        m_valid = id_valid;
        m_ctl = id_valid ? id_ctl : C_NOP;
        m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
        m_rsd = id_rs_data; m_rtd = id_rt_data;
        m_imm = id_imm; m_pc4 = id_pc4;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", 64'(ex_valid), 64'(m_valid));
    chk("ctl", 64'({ex_jump, ex_branch, ex_memread, ex_memtoreg,
                   ex_memwrite, ex_alusrc, ex_regwrite, ex_regdst,
                   ex_aluop}), 64'(m_ctl));
    chk("stall", 64'(stall), 64'(m_stall()));
    chk("cnt", 64'(bubble_cnt), 64'(m_cnt));
    if (m_valid) begin
      chk("rs", 64'(ex_rs), 64'(m_rs));
      chk("rt", 64'(ex_rt), 64'(m_rt));
      chk("rd", 64'(ex_rd), 64'(m_rd));
      chk("rs_data", 64'(ex_rs_data), 64'(m_rsd));
      chk("rt_data", 64'(ex_rt_data), 64'(m_rtd));
      chk("imm", 64'(ex_imm), 64'(m_imm));
      chk("pc4", 64'(ex_pc4), 64'(m_pc4));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [9:0] c, input logic u,
                     input int rs, input int rt, input int rd,
                     input logic [DW-1:0] d);
    id_valid = v; id_ctl = c; id_uses_rt = u;
    id_rs = AW'(rs); id_rt = AW'(rt); id_rd = AW'(rd);
    id_rs_data = d; id_rt_data = d ^ 32'hFFFF;
    id_imm = d + 32'd4; id_pc4 = d << 2;
  endtask

  task automatic nop();
    drv(0, C_NOP, 0, 0, 0, 0, 0);
  endtask

  initial begin
    nop();
    cyc(); cyc();
    rst_n = 1'b1;
    // Pass-through
    cyc();
    drv(1, C_RTYP, 1, 3, 4, 5, 32'h11);
    #1 chk("pt_stall0", 64'(stall), 64'd0);
    cyc();
    nop();
    #1;
    chk("pt_valid", 64'(ex_valid), 64'd1);
    chk("pt_rsdata", 64'(ex_rs_data), 64'h11);
    chk("pt_aluop", 64'(ex_aluop), 64'd2);
    chk("pt_rd", 64'(ex_rd), 64'd5);
    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("rst_regwrite", 64'(ex_regwrite), 64'd0);
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_cnt", 64'(bubble_cnt), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    // Load-use
    drv(1, C_LW, 0, 1, 8, 0, 32'h100);
    cyc();
    drv(1, C_RTYP, 1, 8, 9, 10, 32'h200);
    #1 chk("lu_stall", 64'(stall), 64'd1);
    cyc();
    #1;
    chk("lu_bub_valid", 64'(ex_valid), 64'd0);
    chk("lu_bub_mr", 64'(ex_memread), 64'd0);
    chk("lu_cnt1", 64'(bubble_cnt), 64'd1);
    chk("lu_stall_drop", 64'(stall), 64'd0);
    cyc();
    nop();
    #1;
    chk("lu_add_valid", 64'(ex_valid), 64'd1);
    chk("lu_add_rs", 64'(ex_rs), 64'd8);
    // rt gating
    drv(1, C_LW, 0, 1, 8, 0, 32'h300);
    cyc();
    drv(1, C_ADDI, 0, 2, 8, 0, 32'h310);
    #1 chk("addi_nostall", 64'(stall), 64'd0);
    cyc();
    drv(1, C_LW, 0, 1, 8, 0, 32'h320);
    cyc();
    drv(1, C_SW, 1, 2, 8, 0, 32'h330);
    #1 chk("sw_stall", 64'(stall), 64'd1);
    cyc(); cyc();
    drv(1, C_LW, 0, 1, 0, 0, 32'h340);
    cyc();
    drv(1, C_RTYP, 1, 0, 0, 6, 32'h350);
    #1 chk("r0_nostall", 64'(stall), 64'd0);
    cyc();
    // Flush
    drv(1, C_BEQ, 1, 1, 2, 0, 32'h400);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    nop();
    #1;
    chk("fl_valid", 64'(ex_valid), 64'd0);
    chk("fl_branch", 64'(ex_branch), 64'd0);
    chk("fl_cnt", 64'(bubble_cnt), 64'd2);
    // Flush and stall together
    drv(1, C_LW, 0, 1, 8, 0, 32'h500);
    cyc();
    drv(1, C_RTYP, 1, 8, 9, 10, 32'h510);
    flush = 1'b1;
    #1 chk("fs_stall", 64'(stall), 64'd1);
    cyc();
    flush = 1'b0;
    nop();
    #1 chk("fs_cnt", 64'(bubble_cnt), 64'd2);
    // Hold with changing inputs
    drv(1, C_RTYP, 1, 3, 4, 5, 32'h600);
    cyc();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1, C_LW, 0, 7 + i, 11 + i, 20 + i, 32'h700 + 32'(i));
      cyc();
      #1;
      chk("hold_rs", 64'(ex_rs), 64'd3);
      chk("hold_rd", 64'(ex_rd), 64'd5);
      chk("hold_ctl", 64'(ex_regdst), 64'd1);
    end
    hold = 1'b0;
    // Hold during a hazard keeps the load and does not count
    drv(1, C_LW, 0, 1, 8, 0, 32'h800);
    cyc();
    hold = 1'b1;
    drv(1, C_RTYP, 1, 8, 9, 10, 32'h810);
    cyc();
    #1;
    chk("hh_stall", 64'(stall), 64'd1);
    chk("hh_mr", 64'(ex_memread), 64'd1);
    chk("hh_cnt", 64'(bubble_cnt), 64'd2);
    hold = 1'b0;
    cyc();
    #1 chk("hh_cnt3", 64'(bubble_cnt), 64'd3);
    cyc();
    // Saturation
    for (int i = 0; i < 20; i++) begin
      drv(1, C_LW, 0, 1, 8, 0, 32'h900 + 32'(i));
      cyc();
      drv(1, C_RTYP, 1, 8, 9, 10, 32'hA00 + 32'(i));
      cyc();
      cyc();
    end
    nop();
    cyc();
    #1 chk("sat_cnt", 64'(bubble_cnt), 64'd15);
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
